// File: rtl/ann_sequencer.sv
// rtl/ann_sequencer.sv - sequencing controller for a two-input ANN neuron sharing one pipelined multiplier
//
// Computes y = A*dw1 + B*dw2 + (A*dw1 + B*dw2)*dw3, modulo 2^WIDTH, by running
// the three products one after another through a single multiplier whose
// latency is MUL_STAGES clock edges.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand set on a/b/dw1/dw2/dw3 is valid
//   in_ready   block accepts operands (IDLE only)
//   a, b       neuron inputs
//   dw1..dw3   weights
//   out_valid  y holds a completed result (DONE only)
//   out_ready  consumer accepts y
//   y          registered result
//   busy       any state other than IDLE

module ann_sequencer #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] dw1,
  input  logic [WIDTH-1:0] dw2,
  input  logic [WIDTH-1:0] dw3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  localparam int CW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_M1,
    S_M2,
    S_M3,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, b_q, dw1_q, dw2_q, dw3_q;
  logic [WIDTH-1:0] x_q, z_q, g_q, y_q;

  logic [WIDTH-1:0] mul_op_a, mul_op_b;
  logic [WIDTH-1:0] mul_raw, mul_res;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  // Status flags decode straight from the state register so that neither
  // handshake input can reach them combinationally.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign y         = y_q;

  // Operand select is a function of state only, so it holds steady for the
  // whole M state while the product flows through the pipeline.
  always_comb begin
    mul_op_a = '0;
    mul_op_b = '0;
    case (state_q)
      S_M1: begin
        mul_op_a = a_q;
        mul_op_b = dw1_q;
      end
      S_M2: begin
        mul_op_a = b_q;
        mul_op_b = dw2_q;
      end
      S_M3: begin
        mul_op_a = g_q;
        mul_op_b = dw3_q;
      end
      default: begin
        mul_op_a = '0;
        mul_op_b = '0;
      end
    endcase
  end

  // Low WIDTH bits of the product; identical for signed and unsigned operands.
  assign mul_raw = mul_op_a * mul_op_b;

  // The capture register downstream supplies the last edge of latency, so the
  // multiplier itself carries MUL_STAGES-1 pipeline registers.
  if (MUL_STAGES == 1) begin : g_mul_comb
    assign mul_res = mul_raw;
  end else begin : g_mul_pipe
    logic [WIDTH-1:0] pipe_q [MUL_STAGES-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < MUL_STAGES - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= mul_raw;
        for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign mul_res = pipe_q[MUL_STAGES-2];
  end

  // Next state and stage counter; the counter clears on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (in_valid) state_d = S_M1;
      end
      S_M1: begin
        if (cnt_last) begin
          state_d = S_M2;
          cnt_d   = '0;
        end
      end
      S_M2: begin
        if (cnt_last) begin
          state_d = S_M3;
          cnt_d   = '0;
        end
      end
      S_M3: begin
        if (cnt_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        cnt_d = '0;
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dw1_q   <= '0;
      dw2_q   <= '0;
      dw3_q   <= '0;
      x_q     <= '0;
      z_q     <= '0;
      g_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (state_q == S_IDLE && in_valid) begin
        a_q   <= a;
        b_q   <= b;
        dw1_q <= dw1;
        dw2_q <= dw2;
        dw3_q <= dw3;
      end

      if (cnt_last) begin
        case (state_q)
          S_M1: x_q <= mul_res;
          S_M2: begin
            z_q <= mul_res;
            // g is formed from the product being captured, not from z_q,
            // so it is ready as the M3 operand on the very next cycle.
            g_q <= x_q + mul_res;
          end
          S_M3: y_q <= mul_res + g_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ann_sequencer.sv
// tb/tb_ann_sequencer.sv - randomized self-checking bench for ann_sequencer (MUL_STAGES 1 and 3)

module tb_ann_sequencer;

  logic        clk = 1'b0;
  int          cyc = 0;

  logic        rst_v  [2];
  logic        iv_v   [2];
  logic        ir_v   [2];
  logic        ov_v   [2];
  logic        ordy_v [2];
  logic        busy_v [2];
  logic [31:0] a_v    [2];
  logic [31:0] b_v    [2];
  logic [31:0] w1_v   [2];
  logic [31:0] w2_v   [2];
  logic [31:0] w3_v   [2];
  logic [31:0] y_v    [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ann_sequencer #(.WIDTH(32), .MUL_STAGES(1)) u_dut1 (
    .clk(clk), .reset(rst_v[0]), .in_valid(iv_v[0]), .in_ready(ir_v[0]),
    .a(a_v[0]), .b(b_v[0]), .dw1(w1_v[0]), .dw2(w2_v[0]), .dw3(w3_v[0]),
    .out_valid(ov_v[0]), .out_ready(ordy_v[0]), .y(y_v[0]), .busy(busy_v[0])
  );

  ann_sequencer #(.WIDTH(32), .MUL_STAGES(3)) u_dut3 (
    .clk(clk), .reset(rst_v[1]), .in_valid(iv_v[1]), .in_ready(ir_v[1]),
    .a(a_v[1]), .b(b_v[1]), .dw1(w1_v[1]), .dw2(w2_v[1]), .dw3(w3_v[1]),
    .out_valid(ov_v[1]), .out_ready(ordy_v[1]), .y(y_v[1]), .busy(busy_v[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // Neuron output: the weighted sum s scaled by (1 + dw3), modulo 2^32.
  function automatic logic [31:0] ref_y(input logic [31:0] ta, input logic [31:0] tb,
                                        input logic [31:0] t1, input logic [31:0] t2,
                                        input logic [31:0] t3);
    logic [31:0] s;
    logic [31:0] k;
    s = ta * t1 + tb * t2;
    k = t3 + 32'd1;
    return s * k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input int d);
    a_v[d]  = $urandom;
    b_v[d]  = $urandom;
    w1_v[d] = $urandom;
    w2_v[d] = $urandom;
    w3_v[d] = $urandom;
  endtask

  // One full transaction: accept, compute, hold for bp cycles, handshake.
  // Leaves in_valid high with junk operands; the next call replaces them
  // before the following edge.
  task automatic run_txn(input int d, input logic [31:0] ta, input logic [31:0] tb,
                         input logic [31:0] t1, input logic [31:0] t2, input logic [31:0] t3,
                         input int bp, output int acc_cyc);
    int          ns;
    int          lat;
    logic [31:0] exp;
    logic [31:0] yh;
    ns  = (d == 0) ? 1 : 3;
    exp = ref_y(ta, tb, t1, t2, t3);
    check("pre_in_ready", 32'(ir_v[d]), 32'd1);
    a_v[d]    = ta;
    b_v[d]    = tb;
    w1_v[d]   = t1;
    w2_v[d]   = t2;
    w3_v[d]   = t3;
    iv_v[d]   = 1'b1;
    ordy_v[d] = (bp == 0);
    tick();
    acc_cyc = cyc;
    check("busy_after_accept", 32'(busy_v[d]), 32'd1);
    check("in_ready_busy", 32'(ir_v[d]), 32'd0);
    lat = 0;
    while (!ov_v[d] && lat < 64) begin
      scramble(d);
      iv_v[d] = 1'($urandom_range(0, 1));
      check("busy_during_op", 32'(busy_v[d]), 32'd1);
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(3 * ns));
    check("y_result", y_v[d], exp);
    yh = y_v[d];
    iv_v[d] = 1'b1;
    for (int i = 0; i < bp; i++) begin
      scramble(d);
      tick();
      check("bp_y_stable", y_v[d], yh);
      check("bp_out_valid", 32'(ov_v[d]), 32'd1);
      check("bp_in_ready", 32'(ir_v[d]), 32'd0);
    end
    ordy_v[d] = 1'b1;
    tick();
    ordy_v[d] = 1'b0;
    check("in_ready_after_hs", 32'(ir_v[d]), 32'd1);
    check("out_valid_after_hs", 32'(ov_v[d]), 32'd0);
    check("y_kept_after_hs", y_v[d], yh);
  endtask

  task automatic reset_mid(input int d);
    int   ns;
    logic seen;
    int   c;
    ns = (d == 0) ? 1 : 3;
    scramble(d);
    iv_v[d]   = 1'b1;
    ordy_v[d] = 1'b1;
    tick();
    iv_v[d] = 1'b0;
    for (int i = 0; i < ns + ((ns > 1) ? 1 : 0); i++) begin
      scramble(d);
      tick();
    end
    rst_v[d] = 1'b1;
    iv_v[d]  = 1'b1;
    tick();
    rst_v[d] = 1'b0;
    iv_v[d]  = 1'b0;
    check("rst_out_valid", 32'(ov_v[d]), 32'd0);
    check("rst_busy", 32'(busy_v[d]), 32'd0);
    check("rst_in_ready", 32'(ir_v[d]), 32'd1);
    check("rst_y", y_v[d], 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 3 * ns + 3; i++) begin
      tick();
      if (ov_v[d]) seen = 1'b1;
    end
    check("no_ov_after_rst", 32'(seen), 32'd0);
    run_txn(d, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 0, c);
    check("post_rst_y4", y_v[d], 32'd4);
    iv_v[d] = 1'b0;
    tick();
  endtask

  initial begin
    int c1;
    int c2;
    int ns;
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; iv_v[d] = 1'b0; ordy_v[d] = 1'b0;
      a_v[d] = '0; b_v[d] = '0; w1_v[d] = '0; w2_v[d] = '0; w3_v[d] = '0;
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("reset_in_ready", 32'(ir_v[d]), 32'd1);
      check("reset_busy", 32'(busy_v[d]), 32'd0);
      check("reset_out_valid", 32'(ov_v[d]), 32'd0);
      check("reset_y", y_v[d], 32'd0);
      rst_v[d] = 1'b0;
    end
    tick();

    for (int d = 0; d < 2; d++) begin
      ns = (d == 0) ? 1 : 3;
      run_txn(d, 32'd3, 32'd5, 32'd2, 32'd4, 32'd10, 0, c1);
      check("basic_286", y_v[d], 32'h11E);
      run_txn(d, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1, 32'd7, 0, c2);
      check("wrap1_zero", y_v[d], 32'd0);
      check("back_to_back_ii", 32'(c2 - c1), 32'(3 * ns + 2));
      run_txn(d, 32'h1_0000, 32'd0, 32'h1_0000, 32'd0, 32'd5, 6, c1);
      check("wrap2_zero", y_v[d], 32'd0);
      run_txn(d, 32'd3, 32'd5, 32'd2, 32'd4, 32'd10, 0, c2);
      check("accept_after_bp", 32'(c2 - c1), 32'(3 * ns + 8));
      iv_v[d] = 1'b0;
      tick();
      reset_mid(d);
      for (int t = 0; t < 30; t++) begin
        logic [31:0] r[5];
        for (int j = 0; j < 5; j++) begin
          r[j] = $urandom;
          if ($urandom_range(0, 7) == 0) r[j] = 32'hFFFF_FFFF;
        end
        run_txn(d, r[0], r[1], r[2], r[3], r[4], int'($urandom_range(0, 3)), c1);
      end
      iv_v[d] = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
